// File: rtl/seq_divider_if.sv
// ============================================================================
// seq_divider_if : operand/result handshake bundle for seq_divider
// Revision 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if #(
  parameter int A_DW = 11,
  parameter int B_DW = 11
);
  logic            div_in_vld;
  logic            div_in_rdy;
  logic [A_DW-1:0] div_in1;
  logic [B_DW-1:0] div_in2;
  logic            div_out_vld;
  logic            div_out_rdy;
  logic [A_DW-1:0] quot;
  logic [B_DW-1:0] rem;
  logic            div_by_zero;

  modport master (
    output div_in_vld, div_in1, div_in2, div_out_rdy,
    input  div_in_rdy, div_out_vld, quot, rem, div_by_zero
  );

  modport slave (
    input  div_in_vld, div_in1, div_in2, div_out_rdy,
    output div_in_rdy, div_out_vld, quot, rem, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : radix-2 restoring divider, one quotient bit per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0,
  parameter int A_DW     = 11,
  parameter int B_DW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  dif
);

  localparam int CW = $clog2(A_DW);
  localparam logic [CW-1:0] C_LAST = CW'(A_DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [B_DW-1:0] mag_b_q, mag_b_d;
  logic [A_DW-1:0] qsr_q, qsr_d;
  logic [B_DW-1:0] part_q, part_d;
  logic [A_DW-1:0] quot_q, quot_d;
  logic [B_DW-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            out_vld_q, out_vld_d;

  logic            w_neg_a;
  logic            w_neg_b;
  logic [A_DW-1:0] w_mag_a;
  logic [B_DW-1:0] w_mag_b;
  logic [B_DW:0]   w_r_shift;
  logic            w_ge;
  logic [B_DW-1:0] w_r_sub;

  assign w_neg_a = (A_SIGNED != 0) && dif.div_in1[A_DW-1];
  assign w_neg_b = (B_SIGNED != 0) && dif.div_in2[B_DW-1];
  // Two's-complement negate leaves the most-negative value unchanged,
  // which read as unsigned is exactly its magnitude.
  assign w_mag_a = w_neg_a ? (~dif.div_in1 + 1'b1) : dif.div_in1;
  assign w_mag_b = w_neg_b ? (~dif.div_in2 + 1'b1) : dif.div_in2;

  // Partial remainder stays below the divisor, so B_DW bits hold it and
  // the shifted trial value needs just one extra bit.
  assign w_r_shift = {part_q, qsr_q[A_DW-1]};
  assign w_ge      = (w_r_shift >= {1'b0, mag_b_q});
  assign w_r_sub   = B_DW'(w_r_shift - {1'b0, mag_b_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    mag_b_d   = mag_b_q;
    qsr_d     = qsr_q;
    part_d    = part_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    out_vld_d = out_vld_q;

    case (state_q)
      S_IDLE: begin
        if (dif.div_in_vld) begin
          neg_a_d = w_neg_a;
          neg_b_d = w_neg_b;
          mag_b_d = w_mag_b;
          qsr_d   = w_mag_a;
          part_d  = '0;
          cnt_d   = '0;
          if (dif.div_in2 == '0) begin
            state_d   = S_DONE;
            quot_d    = '1;
            rem_d     = '0;
            dbz_d     = 1'b1;
            out_vld_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (w_ge) begin
          part_d = w_r_sub;
          qsr_d  = {qsr_q[A_DW-2:0], 1'b1};
        end else begin
          part_d = w_r_shift[B_DW-1:0];
          qsr_d  = {qsr_q[A_DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        quot_d    = (neg_a_q ^ neg_b_q) ? (~qsr_q + 1'b1) : qsr_q;
        rem_d     = neg_a_q ? (~part_q + 1'b1) : part_q;
        dbz_d     = 1'b0;
        out_vld_d = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        if (dif.div_out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      mag_b_q   <= '0;
      qsr_q     <= '0;
      part_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      mag_b_q   <= mag_b_d;
      qsr_q     <= qsr_d;
      part_q    <= part_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign dif.div_in_rdy  = (state_q == S_IDLE);
  assign dif.div_out_vld = out_vld_q;
  assign dif.quot        = quot_q;
  assign dif.rem         = rem_q;
  assign dif.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : scoreboard bench, four 8/8 signedness variants in lockstep
// plus a 16/5 unsigned instance. Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_vld;
  logic [7:0] in1, in2;
  logic       out_rdy;

  logic [16:0] res  [4];
  logic        ovld [4];
  logic        irdy [4];

  int checks = 0;
  int errors = 0;

  logic [3:0][16:0] sb_q[$];
  logic [21:0]      as_q[$];

  // Variant k: A_SIGNED = k/2, B_SIGNED = k%2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    seq_divider_if #(.A_DW(8), .B_DW(8)) dif ();
    assign dif.div_in_vld  = in_vld;
    assign dif.div_in1     = in1;
    assign dif.div_in2     = in2;
    assign dif.div_out_rdy = out_rdy;
    assign res[g]  = {dif.div_by_zero, dif.quot, dif.rem};
    assign ovld[g] = dif.div_out_vld;
    assign irdy[g] = dif.div_in_rdy;
    seq_divider #(.A_SIGNED(g / 2), .B_SIGNED(g % 2), .A_DW(8), .B_DW(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dif   (dif)
    );
  end

  logic        as_vld;
  logic [15:0] as_a;
  logic [4:0]  as_b;
  seq_divider_if #(.A_DW(16), .B_DW(5)) if_as ();
  assign if_as.div_in_vld  = as_vld;
  assign if_as.div_in1     = as_a;
  assign if_as.div_in2     = as_b;
  assign if_as.div_out_rdy = 1'b1;
  seq_divider #(.A_SIGNED(0), .B_SIGNED(0), .A_DW(16), .B_DW(5)) u_asym (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (if_as)
  );

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input int adw, input int bdw, input bit asg, input bit bsg,
                                output logic dbz, output logic [15:0] q, output logic [15:0] r);
    longint av, bv, qi, ri;
    av = longint'(a) & ((longint'(1) << adw) - 1);
    bv = longint'(b) & ((longint'(1) << bdw) - 1);
    if (asg && av[adw-1]) av = av - (longint'(1) << adw);
    if (bsg && bv[bdw-1]) bv = bv - (longint'(1) << bdw);
    if (bv == 0) begin
      dbz = 1'b1; q = 16'hFFFF; r = 16'h0;
    end else begin
      qi = av / bv;
      ri = av % bv;
      dbz = 1'b0; q = qi[15:0]; r = ri[15:0];
    end
  endfunction

  function automatic logic [3:0][16:0] exp8(input logic [7:0] a, input logic [7:0] b);
    logic [3:0][16:0] e;
    logic d;
    logic [15:0] q, r;
    for (int k = 0; k < 4; k++) begin
      model({8'h0, a}, {8'h0, b}, 8, 8, bit'(k / 2), bit'(k % 2), d, q, r);
      e[k] = {d, q[7:0], r[7:0]};
    end
    return e;
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] ex [5];
    ex = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return ex[$urandom_range(0, 4)];
    return 8'($urandom());
  endfunction

  // Leaves the bench at the falling edge just after the accept edge.
  task automatic offer8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in1 = a; in2 = b; in_vld = 1'b1;
    for (int n = 0; n < 40 && !irdy[0]; n++) @(negedge clk);
    sb_q.push_back(exp8(a, b));
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to the one raising vld.
  task automatic wait8(output int lat, output bit to);
    lat = 1;
    while (!ovld[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    to = !ovld[0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; in1 = '0; in2 = '0; out_rdy = 1'b1;
    as_vld = 1'b0; as_a = '0; as_b = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({irdy[k], ovld[k], res[k]} !== {1'b1, 1'b0, 17'h0}) begin
        errors++;
        $display("FAIL reset dut%0d got %h expected %h", k, {irdy[k], ovld[k], res[k]}, {1'b1, 1'b0, 17'h0});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat; bit to;
    logic [3:0][16:0] e;
    offer8(8'd200, 8'd7);
    wait8(lat, to);
    checks++;
    if (to || lat != 10) begin errors++; $display("FAIL unsigned_latency got %0d expected 10", lat); end
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res[k] !== e[k]) begin errors++; $display("FAIL unsigned dut%0d got %h expected %h", k, res[k], e[k]); end
    end
    checks++;
    if (res[0] !== {1'b0, 8'd28, 8'd4}) begin errors++; $display("FAIL unsigned_200_7 got %h expected %h", res[0], {1'b0, 8'd28, 8'd4}); end
  endtask

  task automatic test_signed();
    int lat; bit to;
    logic [3:0][16:0] e;
    logic [7:0]  a_t [3];
    logic [7:0]  b_t [3];
    logic [16:0] s_t [3];
    a_t = '{8'h9C, 8'h64, 8'h80};
    b_t = '{8'h07, 8'hF9, 8'hFF};
    s_t = '{{1'b0, 8'hF2, 8'hFE}, {1'b0, 8'hF2, 8'h02}, {1'b0, 8'h80, 8'h00}};
    for (int i = 0; i < 3; i++) begin
      offer8(a_t[i], b_t[i]);
      wait8(lat, to);
      checks++;
      if (to || lat != 10) begin errors++; $display("FAIL signed_latency case%0d got %0d expected 10", i, lat); end
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (res[k] !== e[k]) begin errors++; $display("FAIL signed case%0d dut%0d got %h expected %h", i, k, res[k], e[k]); end
      end
      checks++;
      if (res[3] !== s_t[i]) begin errors++; $display("FAIL signed_literal case%0d got %h expected %h", i, res[3], s_t[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit to;
    logic [3:0][16:0] e;
    offer8(8'd55, 8'd0);
    wait8(lat, to);
    checks++;
    if (to || lat != 1) begin errors++; $display("FAIL dbz_latency got %0d expected 1", lat); end
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res[k] !== {1'b1, 8'hFF, 8'h00}) begin errors++; $display("FAIL dbz dut%0d got %h expected %h", k, res[k], {1'b1, 8'hFF, 8'h00}); end
    end
    offer8(8'd9, 8'd3);
    wait8(lat, to);
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (to || res[k] !== e[k] || res[k] !== {1'b0, 8'd3, 8'd0}) begin
        errors++; $display("FAIL after_dbz dut%0d got %h expected %h", k, res[k], {1'b0, 8'd3, 8'd0});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    logic [3:0][16:0] e;
    logic [16:0] snap [4];
    offer8(8'd10, 8'd3);
    wait8(lat, to);
    out_rdy = 1'b0;
    in1 = 8'd77; in2 = 8'd5; in_vld = 1'b1;
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      snap[k] = res[k];
      checks++;
      if (to || res[k] !== e[k]) begin errors++; $display("FAIL bp_result dut%0d got %h expected %h", k, res[k], e[k]); end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({ovld[k], irdy[k], res[k]} !== {1'b1, 1'b0, snap[k]}) begin
          errors++;
          $display("FAIL bp_hold cyc%0d dut%0d got %h expected %h", c, k, {ovld[k], irdy[k], res[k]}, {1'b1, 1'b0, snap[k]});
        end
      end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ovld[k], irdy[k], res[k]} !== {1'b0, 1'b1, snap[k]}) begin
        errors++; $display("FAIL bp_release dut%0d got %h expected %h", k, {ovld[k], irdy[k], res[k]}, {1'b0, 1'b1, snap[k]});
      end
    end
    sb_q.push_back(exp8(8'd77, 8'd5));
    @(negedge clk);
    in_vld = 1'b0;
    wait8(lat, to);
    checks++;
    if (to || lat != 10) begin errors++; $display("FAIL bp_pending_latency got %0d expected 10", lat); end
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res[k] !== e[k]) begin errors++; $display("FAIL bp_pending dut%0d got %h expected %h", k, res[k], e[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to; bit seen;
    logic [3:0][16:0] e;
    offer8(8'd100, 8'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({irdy[k], ovld[k], res[k]} !== {1'b1, 1'b0, 17'h0}) begin
        errors++; $display("FAIL midreset dut%0d got %h expected %h", k, {irdy[k], ovld[k], res[k]}, {1'b1, 1'b0, 17'h0});
      end
    end
    rst_n = 1'b1;
    sb_q.delete();
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (ovld[k]) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL aborted_vld got 1 expected 0"); end
    offer8(8'd81, 8'd9);
    wait8(lat, to);
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (to || res[k] !== e[k] || res[k] !== {1'b0, 8'd9, 8'd0}) begin
        errors++; $display("FAIL post_reset_81_9 dut%0d got %h expected %h", k, res[k], {1'b0, 8'd9, 8'd0});
      end
    end
  endtask

  task automatic test_asym();
    logic d; logic [15:0] q, r;
    logic [21:0] e, got;
    int lat;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 0) begin as_a = 16'hFFFF; as_b = 5'd31; end
      else if (i == 1) begin as_a = 16'd0; as_b = 5'd1; end
      else begin as_a = 16'($urandom()); as_b = 5'($urandom()); end
      as_vld = 1'b1;
      for (int n = 0; n < 40 && !if_as.div_in_rdy; n++) @(negedge clk);
      model(as_a, {11'h0, as_b}, 16, 5, 1'b0, 1'b0, d, q, r);
      as_q.push_back({d, q, r[4:0]});
      @(negedge clk);
      as_vld = 1'b0;
      lat = 1;
      while (!if_as.div_out_vld && lat < 40) begin @(negedge clk); lat++; end
      e = as_q.pop_front();
      got = {if_as.div_by_zero, if_as.quot, if_as.rem};
      checks++;
      if (!if_as.div_out_vld || got !== e || (as_b != 0 && lat != 18)) begin
        errors++; $display("FAIL asym op%0d got %h lat %0d expected %h", i, got, lat, e);
      end
      if (i == 0) begin
        checks++;
        if (got !== {1'b0, 16'd2114, 5'd1}) begin errors++; $display("FAIL asym_65535_31 got %h expected %h", got, {1'b0, 16'd2114, 5'd1}); end
      end
    end
  endtask

  task automatic test_random();
    int lat; bit to;
    logic [3:0][16:0] e;
    for (int i = 0; i < 1500; i++) begin
      offer8(pick(), pick());
      wait8(lat, to);
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (to || res[k] !== e[k]) begin
          errors++; $display("FAIL random op%0d dut%0d a %h b %h got %h expected %h", i, k, in1, in2, res[k], e[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_asym();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
